// File: rtl/writeback_ctrl.sv
// Register-file writeback controller: merges load and ALU results into an
// in-order pending-write queue, drains one write per cycle and forwards pending values to decode.
module writeback_ctrl #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              drain_en,
    output logic              in_ready,
    output logic              Escrita,
    output logic [ADDR_W-1:0] regDestino,
    output logic [DATA_W-1:0] dadosEscritos,
    input  logic [ADDR_W-1:0] fwd_reg,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              overflow,
    output logic              bad_dest
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(DEPTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Registers 5 and 6 are reserved and must never be written back.
    function automatic logic is_bad_dest(input logic [ADDR_W-1:0] dest);
        return (dest == ADDR_W'(3'd5)) || (dest == ADDR_W'(3'd6));
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_next_s;
    logic [ADDR_W-1:0] dest_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];

    logic              in_ready_s;
    logic              pop_s;
    logic              mem_enq_s;
    logic              alu_enq_s;
    logic              drop_s;
    logic              bad_seen_s;
    logic [CNT_W-1:0]  enq_cnt_s;
    logic [PTR_W-1:0]  alu_slot_s;

    logic              escrita_r;
    logic [ADDR_W-1:0] reg_dest_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              overflow_r;
    logic              bad_dest_r;
    logic              fwd_hit_s;
    logic [DATA_W-1:0] fwd_data_s;

    // Enqueue qualification: a cycle with insufficient room drops both sources.
    always_comb begin
        drop_s     = (mem_valid || alu_valid) && !in_ready_s;
        bad_seen_s = (mem_valid && is_bad_dest(mem_dest)) ||
                     (alu_valid && is_bad_dest(alu_dest));
        mem_enq_s  = mem_valid && in_ready_s && !is_bad_dest(mem_dest);
        alu_enq_s  = alu_valid && in_ready_s && !is_bad_dest(alu_dest);
        enq_cnt_s  = {{(CNT_W-1){1'b0}}, mem_enq_s} + {{(CNT_W-1){1'b0}}, alu_enq_s};
        if (mem_enq_s) begin
            alu_slot_s = tail_r + PTR_W'(1'b1);
        end else begin
            alu_slot_s = tail_r;
        end
        count_next_s = count_r + enq_cnt_s - {{(CNT_W-1){1'b0}}, pop_s};
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enq_cnt_s != {CNT_W{1'b0}}) begin
                    state_next_s = drain_en ? ST_ACTIVE : ST_HOLD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (count_next_s == {CNT_W{1'b0}}) begin
                    state_next_s = ST_IDLE;
                end else if (!drain_en) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_ACTIVE;
                end
            end
            ST_HOLD: begin
                if (count_next_s == {CNT_W{1'b0}}) begin
                    state_next_s = ST_IDLE;
                end else if (drain_en) begin
                    state_next_s = ST_ACTIVE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: pop whenever entries are pending and draining is allowed.
    always_comb begin
        pop_s      = 1'b0;
        in_ready_s = (count_r <= READY_LIMIT);
        case (state_r)
            ST_IDLE:   pop_s = 1'b0;
            ST_ACTIVE: pop_s = drain_en;
            ST_HOLD:   pop_s = drain_en;
            default:   pop_s = 1'b0;
        endcase
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1'b1);
            end else begin
                head_r <= head_r;
            end
            tail_r  <= tail_r + PTR_W'(enq_cnt_s);
            count_r <= count_next_s;
        end
    end

    // Queue storage; the load result takes the older slot.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (mem_enq_s) begin
                dest_mem_r[tail_r] <= mem_dest;
                data_mem_r[tail_r] <= mem_data;
            end
            if (alu_enq_s) begin
                dest_mem_r[alu_slot_s] <= alu_dest;
                data_mem_r[alu_slot_s] <= alu_data;
            end
        end
    end

    // Register-file write port; index and data hold when no write issues.
    always_ff @(posedge clock) begin
        if (reset) begin
            escrita_r  <= 1'b0;
            reg_dest_r <= {ADDR_W{1'b0}};
            wr_data_r  <= {DATA_W{1'b0}};
        end else if (pop_s) begin
            escrita_r  <= 1'b1;
            reg_dest_r <= dest_mem_r[head_r];
            wr_data_r  <= data_mem_r[head_r];
        end else begin
            escrita_r  <= 1'b0;
        end
    end

    // Sticky error flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_r <= 1'b0;
            bad_dest_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | drop_s;
            bad_dest_r <= bad_dest_r | bad_seen_s;
        end
    end

    // Forwarding: scan oldest to youngest so the youngest match overrides.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = {DATA_W{1'b0}};
        if (escrita_r && (reg_dest_r == fwd_reg)) begin
            fwd_hit_s  = 1'b1;
            fwd_data_s = wr_data_r;
        end else begin
            fwd_hit_s  = 1'b0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count_r) &&
                (dest_mem_r[head_r + PTR_W'(k)] == fwd_reg)) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = data_mem_r[head_r + PTR_W'(k)];
            end else begin
                fwd_hit_s  = fwd_hit_s;
            end
        end
    end

    assign in_ready      = in_ready_s;
    assign Escrita       = escrita_r;
    assign regDestino    = reg_dest_r;
    assign dadosEscritos = wr_data_r;
    assign fwd_hit       = fwd_hit_s;
    assign fwd_data      = fwd_data_s;
    assign overflow      = overflow_r;
    assign bad_dest      = bad_dest_r;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Scoreboard bench for writeback_ctrl: directed stimulus pushes expected writes,
// a negedge monitor pops and compares every issued register-file write.
module tb_writeback_ctrl;

    typedef struct packed {
        logic [2:0] dest;
        logic [7:0] data;
    } wr_t;

    logic       clock;
    logic       reset;
    logic       mem_valid;
    logic [2:0] mem_dest;
    logic [7:0] mem_data;
    logic       alu_valid;
    logic [2:0] alu_dest;
    logic [7:0] alu_data;
    logic       drain_en;
    logic       in_ready;
    logic       Escrita;
    logic [2:0] regDestino;
    logic [7:0] dadosEscritos;
    logic [2:0] fwd_reg;
    logic       fwd_hit;
    logic [7:0] fwd_data;
    logic       overflow;
    logic       bad_dest;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total = 0;
    int  bad = 0;
    int  writes_seen = 0;
    int  n_expected = 0;

    writeback_ctrl #(.DEPTH(4), .DATA_W(8), .ADDR_W(3)) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
        .drain_en(drain_en), .in_ready(in_ready),
        .Escrita(Escrita), .regDestino(regDestino), .dadosEscritos(dadosEscritos),
        .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .overflow(overflow), .bad_dest(bad_dest)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired before test end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, req);
        end
    endtask

    // Monitor: every write the DUT issues must match the oldest expected entry.
    always @(negedge clock) begin
        if (Escrita === 1'b1) begin
            writes_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got dest=%0d data=%h expected no write",
                         regDestino, dadosEscritos);
            end else begin
                mon_e = exp_q.pop_front();
                if ({regDestino, dadosEscritos} !== {mon_e.dest, mon_e.data}) begin
                    bad++;
                    $display("FAIL write_order got dest=%0d data=%h expected dest=%0d data=%h",
                             regDestino, dadosEscritos, mon_e.dest, mon_e.data);
                end
            end
        end
    end

    task automatic push(input logic [2:0] d, input logic [7:0] v);
        wr_t w;
        w.dest = d;
        w.data = v;
        exp_q.push_back(w);
        n_expected++;
    endtask

    task automatic issue(input logic mv, input logic [2:0] md, input logic [7:0] mdt,
                         input logic av, input logic [2:0] ad, input logic [7:0] adt,
                         input logic exp_m, input logic exp_a);
        mem_valid = mv; mem_dest = md; mem_data = mdt;
        alu_valid = av; alu_dest = ad; alu_data = adt;
        if (exp_m) push(md, mdt);
        if (exp_a) push(ad, adt);
        @(posedge clock); #1;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clock);
        chk(name, exp_q.size(), 0);
        @(posedge clock); #1;
    endtask

    logic [2:0] d6;
    logic [7:0] v6;
    int         esc_cnt;

    initial begin
        reset = 1'b1; drain_en = 1'b1; fwd_reg = 3'd0;
        mem_valid = 1'b1; mem_dest = 3'd1; mem_data = 8'h77;
        alu_valid = 1'b0; alu_dest = 3'd0; alu_data = 8'h00;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0; mem_valid = 1'b0;
        @(negedge clock);
        chk("rst_escrita", Escrita, 0);
        chk("rst_dest_data", {regDestino, dadosEscritos}, 0);
        chk("rst_flags", {overflow, bad_dest}, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fwd", {fwd_hit, fwd_data}, 0);
        @(posedge clock); #1;

        // single write and its latency
        issue(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        @(negedge clock); chk("single_lat0", Escrita, 0);
        @(negedge clock); chk("single_write", {Escrita, regDestino, dadosEscritos}, {1'b1, 3'd3, 8'h5A});
        @(negedge clock); chk("single_done", Escrita, 0);
        wait_drain("single_drain");

        // dual issue, forwarding the youngest value
        fwd_reg = 3'd2;
        issue(1'b1, 3'd2, 8'h11, 1'b1, 3'd2, 8'h22, 1'b1, 1'b1);
        @(negedge clock); chk("dual_fwd_q", {fwd_hit, fwd_data}, {1'b1, 8'h22});
        @(negedge clock); chk("dual_fwd_w1", {Escrita, dadosEscritos, fwd_hit, fwd_data}, {1'b1, 8'h11, 1'b1, 8'h22});
        @(negedge clock); chk("dual_fwd_w2", {Escrita, dadosEscritos, fwd_hit, fwd_data}, {1'b1, 8'h22, 1'b1, 8'h22});
        @(negedge clock); chk("dual_fwd_end", {Escrita, fwd_hit, fwd_data}, 0);
        chk("dual_hold_out", {regDestino, dadosEscritos}, {3'd2, 8'h22});
        wait_drain("dual_drain");

        // hold/fill and overflow
        drain_en = 1'b0;
        issue(1'b1, 3'd1, 8'hA1, 1'b1, 3'd7, 8'hA2, 1'b1, 1'b1);
        @(negedge clock); chk("fill2_ready", in_ready, 1);
        @(posedge clock); #1;
        issue(1'b1, 3'd1, 8'hA3, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        @(negedge clock); chk("fill3_ready", {in_ready, Escrita}, 0);
        @(posedge clock); #1;
        issue(1'b1, 3'd3, 8'hEE, 1'b1, 3'd0, 8'hEF, 1'b0, 1'b0);
        fwd_reg = 3'd1;
        @(negedge clock); chk("ovf_flag", {overflow, in_ready}, {1'b1, 1'b0});
        chk("fwd_youngest", {fwd_hit, fwd_data}, {1'b1, 8'hA3});
        fwd_reg = 3'd7; #1; chk("fwd_ra", {fwd_hit, fwd_data}, {1'b1, 8'hA2});
        fwd_reg = 3'd3; #1; chk("fwd_dropped", {fwd_hit, fwd_data}, 0);
        fwd_reg = 3'd0; #1; chk("fwd_dropped_alu", {fwd_hit, fwd_data}, 0);
        @(posedge clock); #1;
        drain_en = 1'b1;
        wait_drain("hold_drain");
        chk("after_drain", {overflow, in_ready}, {1'b1, 1'b1});

        // reserved destinations
        issue(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h66, 1'b0, 1'b0);
        @(negedge clock); chk("bad_flag", {bad_dest, Escrita}, {1'b1, 1'b0});
        @(negedge clock); chk("bad_nowrite", Escrita, 0);
        @(posedge clock); #1;
        issue(1'b1, 3'd5, 8'h55, 1'b1, 3'd2, 8'h2B, 1'b0, 1'b1);
        wait_drain("bad_mix_drain");

        // reset with pending entries
        drain_en = 1'b0;
        issue(1'b1, 3'd1, 8'h31, 1'b1, 3'd2, 8'h32, 1'b1, 1'b1);
        issue(1'b1, 3'd3, 8'h33, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        n_expected -= exp_q.size();
        exp_q.delete();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        drain_en = 1'b1;
        fwd_reg = 3'd3;
        @(negedge clock);
        chk("mid_rst_state", {Escrita, fwd_hit, overflow, bad_dest, in_ready}, 5'b00001);
        esc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (Escrita === 1'b1) esc_cnt++;
        end
        chk("mid_rst_nowrite", esc_cnt, 0);
        @(posedge clock); #1;

        // wrap-around: ten back-to-back single enqueues
        for (int i = 0; i < 10; i++) begin
            d6 = 3'(i);
            if (d6 == 3'd5 || d6 == 3'd6) d6 = 3'd7;
            v6 = 8'hC0 + 8'(i);
            issue((i % 2) == 0, d6, v6, (i % 2) == 1, d6, v6, (i % 2) == 0, (i % 2) == 1);
        end
        wait_drain("wrap_drain");

        repeat (3) @(posedge clock);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_write_count", writes_seen, n_expected);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_ctrl.md
WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DEPTH, 4, pending-write queue entries (power of 2, >=2); DATA_W, 8, register data width; ADDR_W, 3, register index width.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_valid  input  1  load result available this cycle.
REQ-005 mem_dest, mem_data  input  ADDR_W, DATA_W  load destination register and value.
REQ-006 alu_valid  input  1  ALU result available this cycle.
REQ-007 alu_dest, alu_data  input  ADDR_W, DATA_W  ALU destination register and value.
REQ-008 drain_en  input  1  when 0, queue holds and no write is issued.
REQ-009 in_ready  output  1  queue can accept two entries this cycle.
REQ-010 Escrita  output  1  register-file write enable (registered).
REQ-011 regDestino, dadosEscritos  output  ADDR_W, DATA_W  register-file write index and data (registered).
REQ-012 fwd_reg  input  ADDR_W  register index being read by decode.
REQ-013 fwd_hit, fwd_data  output  1, DATA_W  pending write to fwd_reg exists; its youngest value.
REQ-014 overflow, bad_dest  output  1, 1  sticky error flags.

Function
REQ-015 Queue SHALL be circular FIFO of DEPTH entries {dest, data} with count 0..DEPTH; pointers wrap modulo DEPTH.
REQ-016 in_ready SHALL be combinational: 1 iff count <= DEPTH-2.
REQ-017 Same-cycle mem_valid and alu_valid SHALL enqueue mem entry first (older), then alu entry.
REQ-018 Entries with dest 5 or 6 SHALL NOT be enqueued; bad_dest SHALL set to 1 and stay until reset.
REQ-019 A valid arriving while in_ready=0 SHALL be dropped entirely (both sources that cycle); overflow SHALL set to 1 and stay until reset.
REQ-020 States: IDLE (count=0), ACTIVE (count>0, drain_en=1), HOLD (count>0, drain_en=0); IDLE->ACTIVE on enqueue with drain_en=1, ACTIVE->HOLD when drain_en falls, HOLD->ACTIVE when drain_en rises, ACTIVE->IDLE when last entry pops with no enqueue.
REQ-021 In ACTIVE, each edge SHALL pop head into output register: Escrita=1, regDestino=head.dest, dadosEscritos=head.data for exactly one cycle per entry.
REQ-022 In IDLE or HOLD, Escrita SHALL be 0 next cycle; regDestino/dadosEscritos SHALL hold last values.
REQ-023 Latency: entry enqueued at edge N into empty queue with drain_en=1 SHALL appear with Escrita=1 after edge N+1.
REQ-024 Simultaneous pop and enqueue SHALL be legal; count changes by (enqueued - popped).
REQ-025 Order SHALL be preserved: writes issue in enqueue order, including dest 7 (ra).
REQ-026 Forwarding SHALL be combinational over all queued entries plus output register when Escrita=1; youngest match wins; fwd_hit=0 and fwd_data=0 when no match.
REQ-027 Incoming same-cycle inputs SHALL NOT participate in forwarding.

Reset
REQ-028 On reset=1 at an edge: count=0, pointers=0, state IDLE, Escrita=0, regDestino=0, dadosEscritos=0, overflow=0, bad_dest=0; inputs that cycle ignored.
REQ-029 Reset mid-drain SHALL discard all pending entries; no write issues after the reset edge.

Verification
REQ-030 Single write: mem_valid, dest 3, data 0x5A, drain_en=1 -> one cycle later Escrita=1, regDestino=3, dadosEscritos=0x5A, then Escrita=0.
REQ-031 Dual issue: mem (2,0x11) and alu (2,0x22) same cycle -> writes 0x11 then 0x22 on consecutive cycles; fwd_reg=2 returns 0x22 until second write completes.
REQ-032 Hold/fill: drain_en=0, enqueue 3 entries (pairs then single) -> in_ready=0 at count 3; further valid sets overflow, count stays 3; drain_en=1 drains 3 writes in order.
REQ-033 Bad destination: alu_valid dest 6 -> no enqueue, bad_dest=1, Escrita stays 0.
REQ-034 Reset mid-operation: 3 queued entries, reset=1 for one edge -> Escrita=0, fwd_hit=0, flags cleared, no further writes.
REQ-035 Wrap-around: 10 sequential single enqueues with drain_en=1 -> 10 writes in order, pointers wrap without loss or duplication.
